// File: rtl/load_store_unit_if.sv
// Pipeline-request, response and data-memory signals of the load/store unit.
// The slave modport is the unit itself; master is the pipeline/memory side.
interface load_store_unit_if #(
  parameter int WORD_ADDR_W = 6
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_wr;
  logic [1:0]             req_size;
  logic                   req_signed;
  logic [WORD_ADDR_W+1:0] req_addr;
  logic [31:0]            req_wdata;

  logic                   rsp_valid;
  logic [31:0]            rsp_rdata;
  logic                   rsp_err;

  logic                   mem_wr;
  logic [WORD_ADDR_W-1:0] mem_addr;
  logic [31:0]            mem_din;
  logic [31:0]            mem_dout;

  modport slave (
    input  req_valid, req_wr, req_size, req_signed, req_addr, req_wdata, mem_dout,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_wr, mem_addr, mem_din
  );

  modport master (
    output req_valid, req_wr, req_size, req_signed, req_addr, req_wdata, mem_dout,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_wr, mem_addr, mem_din
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: byte/half/word access to a word-wide memory,
// sub-word stores by read-modify-write. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module load_store_unit #(
  parameter int WORD_ADDR_W = 6
) (
  input logic               clk,
  input logic               reset,
  load_store_unit_if.slave  lsu
);
  localparam int AW = WORD_ADDR_W + 2;

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_e;

  state_e          state_q;
  logic            wr_q;
  logic [1:0]      size_q;
  logic            signed_q;
  logic [AW-1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic [31:0]     merged_q;
  logic [31:0]     rdata_q;
  logic            err_q;

  logic [AW-1:0]   addr_d;
  logic            trap_d;
  logic [31:0]     lane_mask;
  logic [31:0]     wdata_rep;
  logic [31:0]     shifted;
  logic [31:0]     merged_d;
  logic [31:0]     load_d;

  // size[1] set means word (10 and 11); sub-word addresses are forced to their natural alignment.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    addr_d = lsu.req_addr;
    if (lsu.req_size[1])      addr_d[1:0] = 2'b00;
    else if (lsu.req_size[0]) addr_d[0]   = 1'b0;
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap_d = lsu.req_size[1] ? (lsu.req_addr[1:0] != 2'b00)
                                  : (lsu.req_size[0] & lsu.req_addr[0]);
`else
  assign trap_d = 1'b0;
`endif

  always_comb begin
    lane_mask = 32'hFFFF_FFFF;
    wdata_rep = wdata_q;
    if (!size_q[1]) begin
      if (size_q[0]) begin
        lane_mask = addr_q[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        wdata_rep = {2{wdata_q[15:0]}};
      end else begin
        lane_mask = 32'h0000_00FF << {addr_q[1:0], 3'b000};
        wdata_rep = {4{wdata_q[7:0]}};
      end
    end
    merged_d = (lsu.mem_dout & ~lane_mask) | (wdata_rep & lane_mask);

    shifted = lsu.mem_dout >> {addr_q[1:0], 3'b000};
    load_d  = shifted;
    if (!size_q[1]) begin
      if (size_q[0]) load_d = {{16{signed_q & shifted[15]}}, shifted[15:0]};
      else           load_d = {{24{signed_q & shifted[7]}},  shifted[7:0]};
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_q     <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      merged_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (lsu.req_valid) begin
            wr_q     <= lsu.req_wr;
            size_q   <= lsu.req_size;
            signed_q <= lsu.req_signed;
            addr_q   <= addr_d;
            wdata_q  <= lsu.req_wdata;
            rdata_q  <= '0;
            err_q    <= trap_d;
            state_q  <= trap_d ? RESP : ACCESS;
          end
        end
        ACCESS: begin
          if (!wr_q) begin
            rdata_q <= load_d;
            state_q <= RESP;
          end else if (size_q[1]) begin
            state_q <= RESP;
          end else begin
            merged_q <= merged_d;
            state_q  <= WRITE;
          end
        end
        WRITE:   state_q <= RESP;
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs are qualified by reset so an interrupted store cannot write during the reset cycle.
  assign lsu.req_ready = reset | (state_q == IDLE);
  assign lsu.rsp_valid = ~reset & (state_q == RESP);
  assign lsu.rsp_rdata = rdata_q;
  assign lsu.rsp_err   = err_q;
  assign lsu.mem_wr    = ~reset & ((state_q == WRITE) |
                                   ((state_q == ACCESS) & wr_q & size_q[1]));
  assign lsu.mem_addr  = reset ? '0 : addr_q[AW-1:2];
  assign lsu.mem_din   = reset ? '0 : ((state_q == WRITE) ? merged_q : wdata_q);
endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit with a 64-word behavioural data memory.
module tb_load_store_unit;
  localparam int AW = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  load_store_unit_if #(.WORD_ADDR_W(AW)) lsu_if ();

  load_store_unit #(.WORD_ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .lsu   (lsu_if)
  );

  logic [31:0] mem [64];
  assign lsu_if.mem_dout = mem[lsu_if.mem_addr];
  always @(posedge clk) if (lsu_if.mem_wr) mem[lsu_if.mem_addr] <= lsu_if.mem_din;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    logic        err;
    int          wr_cnt;
    logic [5:0]  maddr;
    logic [31:0] din;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  int n_applied = 0;
  int n_miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic sgn,
                              input logic [7:0] addr, input logic [31:0] wdata, input int lat,
                              input logic [31:0] rdata, input logic err, input int wr_cnt,
                              input logic [5:0] maddr, input logic [31:0] din);
    vec_t v;
    v.wr = wr; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.lat = lat; v.rdata = rdata; v.err = err; v.wr_cnt = wr_cnt; v.maddr = maddr; v.din = din;
    return v;
  endfunction

  task automatic drive_req(input logic wr, input logic [1:0] size, input logic sgn,
                           input logic [7:0] addr, input logic [31:0] wdata);
    lsu_if.req_valid  = 1'b1;
    lsu_if.req_wr     = wr;
    lsu_if.req_size   = size;
    lsu_if.req_signed = sgn;
    lsu_if.req_addr   = addr;
    lsu_if.req_wdata  = wdata;
  endtask

  // Called at a negedge with the unit idle; returns at the negedge after the response.
  task automatic run_vec(input int i);
    vec_t v;
    int lat, wr_cnt;
    logic [5:0] got_addr;
    logic [31:0] got_din, got_rdata;
    logic got_err;
    v = vecs[i];
    lat = 0; wr_cnt = 0; got_addr = '0; got_din = '0; got_rdata = '0; got_err = 1'b0;
    drive_req(v.wr, v.size, v.sgn, v.addr, v.wdata);
    @(negedge clk);
    lsu_if.req_valid = 1'b0;
    for (int n = 1; n <= 6 && lat == 0; n++) begin
      if (n > 1) @(negedge clk);
      if (lsu_if.mem_wr) begin
        wr_cnt++;
        got_addr = lsu_if.mem_addr;
        got_din  = lsu_if.mem_din;
      end
      if (lsu_if.rsp_valid) begin
        lat       = n;
        got_rdata = lsu_if.rsp_rdata;
        got_err   = lsu_if.rsp_err;
      end
    end
    check($sformatf("v%0d latency", i), lat, v.lat);
    check($sformatf("v%0d rdata", i), got_rdata, v.rdata);
    check($sformatf("v%0d err", i), {31'b0, got_err}, {31'b0, v.err});
    check($sformatf("v%0d mem_wr count", i), wr_cnt, v.wr_cnt);
    if (v.wr_cnt == 1) begin
      check($sformatf("v%0d mem_addr", i), {26'b0, got_addr}, {26'b0, v.maddr});
      check($sformatf("v%0d mem_din", i), got_din, v.din);
    end
    @(negedge clk);
    check($sformatf("v%0d rsp pulse width", i), {31'b0, lsu_if.rsp_valid}, 32'd0);
    check($sformatf("v%0d ready after rsp", i), {31'b0, lsu_if.req_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc_cnt, rsp_cnt, wr_seen;

    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[12] = 32'h1122_3344;

    vecs[0]  = mk(1, 2'b10, 0, 8'h10, 32'hDEAD_BEEF, 2, 32'h0, 0, 1, 6'd4, 32'hDEAD_BEEF);
    vecs[1]  = mk(0, 2'b10, 0, 8'h10, 32'h0, 2, 32'hDEAD_BEEF, 0, 0, 6'd0, 32'h0);
    vecs[2]  = mk(1, 2'b00, 0, 8'h11, 32'hAAAA_AA55, 3, 32'h0, 0, 1, 6'd4, 32'hDEAD_55EF);
    vecs[3]  = mk(0, 2'b01, 1, 8'h10, 32'h0, 2, 32'h0000_55EF, 0, 0, 6'd0, 32'h0);
    vecs[4]  = mk(0, 2'b00, 1, 8'h13, 32'h0, 2, 32'hFFFF_FFDE, 0, 0, 6'd0, 32'h0);
    vecs[5]  = mk(0, 2'b00, 0, 8'h13, 32'h0, 2, 32'h0000_00DE, 0, 0, 6'd0, 32'h0);
    vecs[6]  = mk(0, 2'b01, 1, 8'h12, 32'h0, 2, 32'hFFFF_DEAD, 0, 0, 6'd0, 32'h0);
    vecs[7]  = mk(0, 2'b01, 0, 8'h12, 32'h0, 2, 32'h0000_DEAD, 0, 0, 6'd0, 32'h0);
    vecs[8]  = mk(1, 2'b01, 0, 8'h22, 32'h1234_BEEF, 3, 32'h0, 0, 1, 6'd8, 32'hBEEF_0000);
    vecs[9]  = mk(0, 2'b10, 0, 8'h20, 32'h0, 2, 32'hBEEF_0000, 0, 0, 6'd0, 32'h0);
    vecs[10] = mk(0, 2'b00, 0, 8'h22, 32'h0, 2, 32'h0000_00EF, 0, 0, 6'd0, 32'h0);
    vecs[11] = mk(0, 2'b00, 1, 8'h23, 32'h0, 2, 32'hFFFF_FFBE, 0, 0, 6'd0, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[12] = mk(0, 2'b10, 0, 8'h11, 32'h0, 1, 32'h0, 1, 0, 6'd0, 32'h0);
    vecs[13] = mk(1, 2'b01, 0, 8'h25, 32'h0000_CAFE, 1, 32'h0, 1, 0, 6'd0, 32'h0);
    vecs[14] = mk(0, 2'b10, 0, 8'h24, 32'h0, 2, 32'h0, 0, 0, 6'd0, 32'h0);
`else
    vecs[12] = mk(0, 2'b10, 0, 8'h11, 32'h0, 2, 32'hDEAD_55EF, 0, 0, 6'd0, 32'h0);
    vecs[13] = mk(1, 2'b01, 0, 8'h25, 32'h0000_CAFE, 3, 32'h0, 0, 1, 6'd9, 32'h0000_CAFE);
    vecs[14] = mk(0, 2'b10, 0, 8'h24, 32'h0, 2, 32'h0000_CAFE, 0, 0, 6'd0, 32'h0);
`endif
    vecs[15] = mk(1, 2'b11, 0, 8'h2C, 32'h0102_0304, 2, 32'h0, 0, 1, 6'd11, 32'h0102_0304);
    vecs[16] = mk(0, 2'b11, 0, 8'h2C, 32'h0, 2, 32'h0102_0304, 0, 0, 6'd0, 32'h0);
    vecs[17] = mk(0, 2'b00, 1, 8'h2C, 32'h0, 2, 32'h0000_0004, 0, 0, 6'd0, 32'h0);
    vecs[18] = mk(0, 2'b01, 0, 8'h2E, 32'h0, 2, 32'h0000_0102, 0, 0, 6'd0, 32'h0);
    vecs[19] = mk(1, 2'b00, 0, 8'h2F, 32'h0000_0080, 3, 32'h0, 0, 1, 6'd11, 32'h8002_0304);
    vecs[20] = mk(0, 2'b00, 1, 8'h2F, 32'h0, 2, 32'hFFFF_FF80, 0, 0, 6'd0, 32'h0);
    vecs[21] = mk(0, 2'b01, 1, 8'h2E, 32'h0, 2, 32'hFFFF_8002, 0, 0, 6'd0, 32'h0);

    reset = 1'b1;
    drive_req(1'b0, 2'b00, 1'b0, 8'h0, 32'h0);
    lsu_if.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("reset ready", {31'b0, lsu_if.req_ready}, 32'd1);
    check("reset rsp_valid", {31'b0, lsu_if.rsp_valid}, 32'd0);
    check("reset mem_wr", {31'b0, lsu_if.mem_wr}, 32'd0);
    check("reset mem_addr", {26'b0, lsu_if.mem_addr}, 32'd0);
    check("reset mem_din", lsu_if.mem_din, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post-reset rdata", lsu_if.rsp_rdata, 32'd0);
    check("post-reset err", {31'b0, lsu_if.rsp_err}, 32'd0);
    check("post-reset ready", {31'b0, lsu_if.req_ready}, 32'd1);

    for (int i = 0; i < NV; i++) run_vec(i);

    // Reset lands in the WRITE cycle of a halfword store, with a new request held through reset.
    drive_req(1'b1, 2'b01, 1'b0, 8'h30, 32'h0000_ABCD);
    @(negedge clk);
    lsu_if.req_valid = 1'b0;
    check("rmw access mem_wr", {31'b0, lsu_if.mem_wr}, 32'd0);
    @(negedge clk);
    check("rmw write mem_wr", {31'b0, lsu_if.mem_wr}, 32'd1);
    reset = 1'b1;
    drive_req(1'b1, 2'b10, 1'b0, 8'h34, 32'hCAFE_F00D);
    @(negedge clk);
    check("abort mem_wr", {31'b0, lsu_if.mem_wr}, 32'd0);
    check("abort rsp_valid", {31'b0, lsu_if.rsp_valid}, 32'd0);
    check("abort ready", {31'b0, lsu_if.req_ready}, 32'd1);
    check("abort mem_addr", {26'b0, lsu_if.mem_addr}, 32'd0);
    reset = 1'b0;
    lsu_if.req_valid = 1'b0;
    rsp_cnt = 0; wr_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (lsu_if.rsp_valid) rsp_cnt++;
      if (lsu_if.mem_wr) wr_seen++;
    end
    check("abort no rsp", rsp_cnt, 32'd0);
    check("abort no mem_wr", wr_seen, 32'd0);
    check("abort word 12 intact", mem[12], 32'h1122_3344);
    check("reset-cycle req ignored", mem[13], 32'h0);

    // req_valid held high: accepts only while ready, one response per accept.
    acc_cnt = 0; rsp_cnt = 0; wr_seen = 0;
    drive_req(1'b0, 2'b10, 1'b0, 8'h2C, 32'h0);
    for (int k = 0; k < 12; k++) begin
      if (lsu_if.req_ready) acc_cnt++;
      if (lsu_if.rsp_valid) begin
        rsp_cnt++;
        check($sformatf("stream rdata %0d", rsp_cnt), lsu_if.rsp_rdata, 32'h8002_0304);
      end
      if (lsu_if.mem_wr) wr_seen++;
      @(negedge clk);
    end
    lsu_if.req_valid = 1'b0;
    repeat (4) begin
      if (lsu_if.rsp_valid) rsp_cnt++;
      if (lsu_if.mem_wr) wr_seen++;
      @(negedge clk);
    end
    check("stream accepts", acc_cnt, 32'd4);
    check("stream responses", rsp_cnt, 32'd4);
    check("stream no mem_wr", wr_seen, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
    $finish;
  end
endmodule
